// File: rtl/pass_deser.sv
// Serial framing receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define PASS_DESER_PARITY_EN to add the parity bit and parity_err reporting.
module pass_deser #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
`ifdef PASS_DESER_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd2;
`endif
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next, shift_ins;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg, overrun_next;
    logic             word_done;
    logic             parity_bad;

`ifdef PASS_DESER_PARITY_EN
    logic parity_bit_reg, parity_bit_next;
    logic parity_err_reg, parity_err_next;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_bad = ^{shift_reg, parity_bit_reg};
`else
    assign parity_bad = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ins
            assign shift_ins[gi] = (cnt_reg == CW'(gi)) ? in : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        word_done      = 1'b0;
`ifdef PASS_DESER_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        case (state_reg)
            ST_IDLE: begin
                if (in != IDLE_LEVEL) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                shift_next = shift_ins;
                if (cnt_reg == LAST_BIT) begin
`ifdef PASS_DESER_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`ifdef PASS_DESER_PARITY_EN
            ST_PARITY: begin
                parity_bit_next = in;
                state_next      = ST_STOP;
            end
`endif
            ST_STOP: begin
`ifdef PASS_DESER_PARITY_EN
                parity_err_next = parity_bad;
`endif
                if (in == IDLE_LEVEL) begin
                    state_next = ST_IDLE;
                    word_done  = !parity_bad;
                end else begin
                    state_next     = ST_BREAK;
                    frame_err_next = 1'b1;
                end
            end
            ST_BREAK: begin
                if (in == IDLE_LEVEL) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A completed word only displaces the pending one if it is being accepted now.
        if (word_done) begin
            if (!valid_reg || out_ready) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef PASS_DESER_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
`ifdef PASS_DESER_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
`ifdef PASS_DESER_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pass_deser.sv
// Directed bench for pass_deser (WIDTH=8, idle high); parity case built when PASS_DESER_PARITY_EN is defined.
module tb_pass_deser;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    pass_deser #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in         (in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Drive one line bit for one edge; returns 1 time unit after that edge.
    task automatic send_bit(input logic b);
        in = b;
        @(posedge clock);
        #1;
    endtask

    // Start bit, data LSB first, parity bit when compiled in; stop bit is left to the caller.
    task automatic send_body(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
`ifdef PASS_DESER_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        reset_n   = 1'b0;
        in        = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_errs", {frame_err, overrun, parity_err}, 0);
        reset_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);

        // 1: single frame A5 with consumer ready
        out_ready = 1'b1;
        send_body(8'hA5, even_par(8'hA5));
        check("t1_valid_before_stop", out_valid, 0);
        send_bit(1'b1);
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'hA5);
        check("t1_errs", {frame_err, overrun, parity_err}, 0);
        send_bit(1'b1);
        check("t1_valid_one_cycle", out_valid, 0);

        // 2: back-to-back 3C then FF, consumer stalled
        out_ready = 1'b0;
        send_body(8'h3C, even_par(8'h3C));
        send_bit(1'b1);
        check("t2_first_valid", out_valid, 1);
        check("t2_first_data", out_data, 8'h3C);
        check("t2_no_overrun_yet", overrun, 0);
        send_body(8'hFF, even_par(8'hFF));
        send_bit(1'b1);
        check("t2_overrun", overrun, 1);
        check("t2_data_kept", out_data, 8'h3C);
        check("t2_valid_held", out_valid, 1);
        send_bit(1'b1);
        check("t2_overrun_pulse", overrun, 0);
        check("t2_valid_still", out_valid, 1);
        out_ready = 1'b1;
        send_bit(1'b1);
        check("t2_valid_drop", out_valid, 0);

        // 3: bad stop bit, line held low, then a good frame
        send_body(8'h00, even_par(8'h00));
        send_bit(1'b0);
        check("t3_frame_err", frame_err, 1);
        check("t3_no_word", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            check("t3_low_frame_err", frame_err, 0);
            check("t3_low_no_word", out_valid, 0);
        end
        send_bit(1'b1);
        send_body(8'h81, even_par(8'h81));
        send_bit(1'b1);
        check("t3_good_valid", out_valid, 1);
        check("t3_good_data", out_data, 8'h81);
        check("t3_good_errs", {frame_err, overrun}, 0);
        send_bit(1'b1);

        // 4: new word completes on the acceptance edge
        out_ready = 1'b0;
        send_body(8'h11, even_par(8'h11));
        send_bit(1'b1);
        check("t4_pending", out_data, 8'h11);
        send_body(8'h5A, even_par(8'h5A));
        out_ready = 1'b1;
        send_bit(1'b1);
        check("t4_data", out_data, 8'h5A);
        check("t4_valid", out_valid, 1);
        check("t4_no_overrun", overrun, 0);
        send_bit(1'b1);
        check("t4_drained", out_valid, 0);

        // 5: asynchronous reset mid-frame
        out_ready = 1'b0;
        send_body(8'hC3, even_par(8'hC3));
        send_bit(1'b1);
        check("t5_pre_valid", out_valid, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data", out_data, 0);
        check("t5_async_errs", {frame_err, overrun, parity_err}, 0);
        in = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        check("t5_no_stale_word", out_valid, 0);
        send_body(8'h12, even_par(8'h12));
        send_bit(1'b1);
        check("t5_valid", out_valid, 1);
        check("t5_data", out_data, 8'h12);
        check("t5_errs", {frame_err, overrun, parity_err}, 0);
        send_bit(1'b1);

`ifdef PASS_DESER_PARITY_EN
        // 6: parity good then bad
        send_body(8'h07, 1'b1);
        send_bit(1'b1);
        check("t6_good_valid", out_valid, 1);
        check("t6_good_data", out_data, 8'h07);
        check("t6_good_perr", parity_err, 0);
        send_bit(1'b1);
        check("t6_drained", out_valid, 0);
        send_body(8'h07, 1'b0);
        send_bit(1'b1);
        check("t6_parity_err", parity_err, 1);
        check("t6_bad_no_word", out_valid, 0);
        send_bit(1'b1);
        check("t6_parity_pulse", parity_err, 0);
`else
        check("t6_parity_tied", parity_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pass_deser.md
Name: pass_deser

Overview:
- Serial-to-parallel framing receiver that sits directly downstream of the registered single-bit pass stage in the e2e flow test design.
- Samples the 1-bit stream on every rising clock edge and recovers framed words: start bit 0, WIDTH data bits LSB first, optional parity bit, stop bit 1.
- Delivers each word on a valid/ready output port and flags framing, overrun and (optionally) parity faults, giving the flow a non-trivial sequential block behind the pass register.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.
- IDLE_LEVEL, 1, line level between frames; a start bit is the complement of this level. The stop bit equals IDLE_LEVEL.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  1  serial stream, already synchronous to clock (driven by the pass register); no synchronizer.
- out_data  output  WIDTH  recovered word; stable while out_valid=1.
- out_valid  output  1  word available; held until accepted.
- out_ready  input  1  consumer accepts on a clock edge where out_valid&&out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled != IDLE_LEVEL.
- overrun  output  1  one-cycle pulse: a word completed while the previous word was still pending and not accepted.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when the feature is compiled out.

Behaviour:
- Reset (reset_n=0, asynchronous): FSM=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, and all error pulses=0. Reset mid-frame abandons the partial word; no pulse is emitted on release.
- FSM states: IDLE, DATA, PARITY (feature only), STOP, BREAK.
- IDLE: on an edge where in==~IDLE_LEVEL, go to DATA with bit counter=0.
- DATA: shift in into bit position `counter` (LSB first). After WIDTH-1, go to PARITY if enabled, else STOP. Counter width is $clog2(WIDTH); it never wraps past WIDTH-1.
- PARITY: sample the parity bit, then go to STOP.
- STOP, in==IDLE_LEVEL and no parity error: word complete; go to IDLE.
- STOP, in!=IDLE_LEVEL: drop the word, pulse frame_err on the next cycle, go to BREAK.
- BREAK: wait for in==IDLE_LEVEL, then go to IDLE. A held non-idle line therefore never re-triggers a start.
- Latency: with the start bit sampled at edge E0, data is sampled at E1..EWIDTH and the stop bit at EWIDTH+1 (EWIDTH+2 with parity). out_data/out_valid update on that stop edge. A back-to-back start bit can be sampled on the very next edge.
- Handshake:
  - out_valid falls on an edge with out_ready=1 unless a new word completes on the same edge.
  - If a word completes on the same edge as acceptance, load the new word and keep out_valid=1; no overrun.
  - If a word completes while out_valid=1 and out_ready=0, keep the old word, drop the new one, and pulse overrun.
- Error pulses are registered, high for exactly one cycle, and do not affect out_valid.

Optional Feature:
- Macro: PASS_DESER_PARITY_EN.
- Defined:
  - The PARITY state exists and frames carry one even-parity bit after data (XOR of data bits and parity bit must be 0).
  - On mismatch, drop the word, pulse parity_err when the stop edge is reached, and return to IDLE (or BREAK if the stop bit is also bad, with both pulses).
  - Frame length is WIDTH+3.
- Undefined:
  - No PARITY state; frame length is WIDTH+2.
  - parity_err is tied to 0.

Test Plan:
1. WIDTH=8, no parity, reset released, line idle 1. Drive start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, with out_ready=1. Required: out_data=8'hA5 with out_valid=1 for exactly one cycle, after the 10th sampled edge; no error pulses.
2. Two back-to-back frames 8'h3C and 8'hFF with out_ready=0 throughout. Required: out_data remains 8'h3C with out_valid held 1; overrun pulses once at the second stop edge. Then raise out_ready: out_valid drops after one edge.
3. Frame 8'h00 with stop bit 0, then line held 0 for 5 cycles, then 1, then a valid frame 8'h81. Required: frame_err pulses once; no word delivered for the bad frame; no false start while the line is held low; 8'h81 delivered.
4. Word pending; a second frame 8'h5A completes on the same edge that out_ready=1. Required: out_data=8'h5A, out_valid stays 1, no overrun.
5. Assert reset_n=0 asynchronously (mid-cycle) after 4 data bits, release, then send 8'h12. Required: all outputs 0 immediately on assertion; 8'h12 received correctly; no error pulses.
6. With PASS_DESER_PARITY_EN defined: frame 8'h07 with parity 1 → delivered. Same frame with parity 0 → parity_err pulses once, out_valid stays 0.
